// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: BHT entry layout,
// 2-bit counter encodings and the saturating counter update.
package bp_pkg;

    localparam int BHT_IDX_W = 6;
    localparam int BHT_DEPTH = 1 << BHT_IDX_W;
    localparam int TAG_W     = 32 - BHT_IDX_W - 2;

    localparam logic [1:0]  CNT_SNT = 2'b00;
    localparam logic [1:0]  CNT_WNT = 2'b01;
    localparam logic [1:0]  CNT_WT  = 2'b10;
    localparam logic [1:0]  CNT_ST  = 2'b11;

    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       cnt;
        logic [31:0]      target;
    } bht_entry_t;

    // Move a 2-bit counter one step toward the resolved direction, holding at the ends.
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != CNT_ST) begin
                nxt = cnt + 2'd1;
            end else begin
                nxt = cnt;
            end
        end else begin
            if (cnt != CNT_SNT) begin
                nxt = cnt - 2'd1;
            end else begin
                nxt = cnt;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_ctrl_if.sv
// Pipeline-side bus of the branch predictor: IF lookup, EX resolution,
// flush/redirect and performance counters.
// master = pipeline, slave = bp_ctrl.
interface bp_ctrl_if;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_ex_vld;
    logic        i_ex_is_br;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic        o_flush;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;

    modport master (
        output i_if_pc, i_ex_vld, i_ex_is_br, i_ex_pc, i_ex_taken, i_ex_target,
               i_ex_pred_taken, i_ex_pred_target,
        input  o_pred_taken, o_pred_target, o_flush, o_redirect_pc,
               o_br_cnt, o_mispred_cnt
    );

    modport slave (
        input  i_if_pc, i_ex_vld, i_ex_is_br, i_ex_pc, i_ex_taken, i_ex_target,
               i_ex_pred_taken, i_ex_pred_target,
        output o_pred_taken, o_pred_target, o_flush, o_redirect_pc,
               o_br_cnt, o_mispred_cnt
    );
endinterface

// File: rtl/bp_bht.sv
// Branch history table: flop array of {valid, tag, 2-bit counter, target}.
// One combinational read port for IF lookup; one synchronous read-modify-write
// port that trains or allocates the entry of a resolved branch.
// Reset clears valid bits and counters; a write in the reset cycle is dropped.
module bp_bht
    import bp_pkg::*;
(
    input  logic                 i_clk,
    i_rst,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output bht_entry_t           rd_entry,
    input  logic                 wr_en,
    input  logic [BHT_IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic                 wr_taken,
    input  logic [31:0]          wr_target
);

    bht_entry_t mem_r [BHT_DEPTH];
    bht_entry_t cur_s;
    bht_entry_t nxt_s;
    logic       hit_s;
    logic       we_s;

    assign rd_entry = mem_r[rd_idx];
    assign cur_s    = mem_r[wr_idx];
    assign hit_s    = cur_s.valid && (cur_s.tag == wr_tag);

    // Build the new entry: train a hit, allocate on a taken miss, leave a not-taken miss alone.
    always_comb begin
        nxt_s = cur_s;
        we_s  = 1'b0;
        if (wr_en) begin
            if (hit_s) begin
                we_s      = 1'b1;
                nxt_s.cnt = sat_update(cur_s.cnt, wr_taken);
                if (wr_taken) begin
                    nxt_s.target = wr_target;
                end else begin
                    nxt_s.target = cur_s.target;
                end
            end else if (wr_taken) begin
                we_s         = 1'b1;
                nxt_s.valid  = 1'b1;
                nxt_s.tag    = wr_tag;
                nxt_s.cnt    = CNT_WT;
                nxt_s.target = wr_target;
            end else begin
                we_s = 1'b0;
            end
        end else begin
            we_s = 1'b0;
        end
    end

    // Table storage; reset wins over a concurrent update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                mem_r[i].valid <= 1'b0;
                mem_r[i].cnt   <= CNT_SNT;
            end
        end else if (we_s) begin
            mem_r[wr_idx] <= nxt_s;
        end
    end

endmodule

// File: rtl/bp_ctrl.sv
// Dynamic branch predictor and fetch-redirect controller.
// IF lookup and EX flush/redirect are combinational; table updates land on
// the next rising edge with no same-cycle bypass.
// Optional macro BP_PERF_CNT_EN adds saturating branch / mispredict counters.
module bp_ctrl
    import bp_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    bp_ctrl_if.slave bus
);

    logic [BHT_IDX_W-1:0] if_idx_s;
    logic [TAG_W-1:0]     if_tag_s;
    logic [BHT_IDX_W-1:0] ex_idx_s;
    logic [TAG_W-1:0]     ex_tag_s;
    bht_entry_t           if_entry_s;
    logic                 if_hit_s;
    logic                 pred_taken_s;
    logic [31:0]          pred_target_s;
    logic                 res_s;
    logic                 mispred_s;
    logic                 flush_s;
    logic [31:0]          redirect_s;
    logic [31:0]          pc_plus4_s;
    logic                 unused_s;

    assign if_idx_s   = bus.i_if_pc[BHT_IDX_W+1:2];
    assign if_tag_s   = bus.i_if_pc[31:BHT_IDX_W+2];
    assign ex_idx_s   = bus.i_ex_pc[BHT_IDX_W+1:2];
    assign ex_tag_s   = bus.i_ex_pc[31:BHT_IDX_W+2];
    assign pc_plus4_s = bus.i_ex_pc + 32'd4;
    assign unused_s   = ^bus.i_if_pc[1:0];

    bp_bht u_bht (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .rd_idx    (if_idx_s),
        .rd_entry  (if_entry_s),
        .wr_en     (res_s),
        .wr_idx    (ex_idx_s),
        .wr_tag    (ex_tag_s),
        .wr_taken  (bus.i_ex_taken),
        .wr_target (bus.i_ex_target)
    );

    // IF prediction: taken only on a tag hit whose counter is in a taken state.
    always_comb begin
        if_hit_s      = if_entry_s.valid && (if_entry_s.tag == if_tag_s);
        pred_taken_s  = if_hit_s && if_entry_s.cnt[1];
        pred_target_s = 32'd0;
        if (pred_taken_s) begin
            pred_target_s = if_entry_s.target;
        end else begin
            pred_target_s = 32'd0;
        end
    end

    // EX resolution: compare the carried prediction against the outcome and pick the fix-up PC.
    always_comb begin
        res_s      = bus.i_ex_vld && bus.i_ex_is_br;
        mispred_s  = (bus.i_ex_taken != bus.i_ex_pred_taken) ||
                     (bus.i_ex_taken && (bus.i_ex_target != bus.i_ex_pred_target));
        flush_s    = res_s && mispred_s;
        redirect_s = 32'd0;
        if (flush_s) begin
            if (bus.i_ex_taken) begin
                redirect_s = bus.i_ex_target;
            end else begin
                redirect_s = pc_plus4_s;
            end
        end else begin
            redirect_s = 32'd0;
        end
    end

    assign bus.o_pred_taken  = pred_taken_s;
    assign bus.o_pred_target = pred_target_s;
    assign bus.o_flush       = flush_s;
    assign bus.o_redirect_pc = redirect_s;

`ifdef BP_PERF_CNT_EN
    logic [31:0] br_cnt_r;
    logic [31:0] mispred_cnt_r;

    // Saturating counts of resolved branches and of flushes they caused.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_cnt_r      <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (res_s && (br_cnt_r != PERF_CNT_MAX)) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (flush_s && (mispred_cnt_r != PERF_CNT_MAX)) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign bus.o_br_cnt      = br_cnt_r;
    assign bus.o_mispred_cnt = mispred_cnt_r;
`else
    assign bus.o_br_cnt      = 32'd0;
    assign bus.o_mispred_cnt = 32'd0;
`endif

endmodule

// File: doc/bp_ctrl.md
# bp_ctrl

Dynamic branch predictor and fetch-redirect controller for the five-stage RV32I pipeline. It replaces static always-taken next-PC selection with a direct-mapped branch history table (BHT) of 2-bit saturating counters plus stored targets. IF stage looks it up each cycle; EX stage resolves branches back into it and receives the flush/redirect decision.

## Interface
- BHT_IDX_W, 6, index width; table holds 2**BHT_IDX_W entries, indexed by PC[BHT_IDX_W+1:2]
- TAG_W, 32-BHT_IDX_W-2, tag width = PC[31:BHT_IDX_W+2]
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_if_pc  in  32  current fetch PC
- o_pred_taken  out  1  IF prediction: redirect fetch to o_pred_target
- o_pred_target  out  32  predicted target (0 when o_pred_taken=0)
- i_ex_vld  in  1  EX holds a valid, non-flushed instruction
- i_ex_is_br  in  1  EX instruction is BRANCH or JAL (JALR excluded)
- i_ex_pc  in  32  PC of EX instruction
- i_ex_taken  in  1  resolved direction
- i_ex_target  in  32  resolved target
- i_ex_pred_taken  in  1  prediction carried down pipeline with instruction
- i_ex_pred_target  in  32  predicted target carried down pipeline
- o_flush  out  1  flush IF/ID, redirect fetch
- o_redirect_pc  out  32  correct next PC on flush
- o_br_cnt  out  32  resolved branches (macro-gated)
- o_mispred_cnt  out  32  mispredictions (macro-gated)

## Operation
- Entry: valid, tag[TAG_W], cnt[2], target[32]. Counter encoding SNT=00, WNT=01, WT=10, ST=11.
- Lookup (combinational): hit = valid & tag match at index of i_if_pc; o_pred_taken = hit & cnt[1]; o_pred_target = entry target when o_pred_taken, else 0.
- Resolve when res = i_ex_vld & i_ex_is_br:
  - mispred = (i_ex_taken != i_ex_pred_taken) | (i_ex_taken & i_ex_target != i_ex_pred_target).
  - o_flush = res & mispred.
  - o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc+4 (mod 2**32). 0 when o_flush=0.
  - Non-branch EX instructions with a stale prediction are not handled here; the pipeline never predicts taken for a non-hit.
- Update (registered, on res):
  - Hit at i_ex_pc: cnt increments on taken, decrements on not-taken, saturating at ST/SNT. Target overwritten with i_ex_target on taken.
  - Miss, taken: allocate. valid=1, tag, cnt=WT, target = i_ex_target. Overwrites any conflicting entry.
  - Miss, not taken: no change.

## Timing
- Prediction: 0-cycle latency from i_if_pc.
- Flush/redirect: 0-cycle latency from EX inputs.
- Table update visible to lookups in the cycle after resolution.
- Same-index lookup and update in one cycle: lookup returns the pre-update entry (no bypass).
- Reset (any cycle, including mid-update):
  - All valid bits cleared next edge.
  - Counters cleared.
  - Update in that cycle discarded.
- Output values:
  - Combinational outputs are 0 whenever the table is empty and EX is idle.
  - o_flush is never asserted while i_ex_vld=0.

## Configuration
- BP_PERF_CNT_EN defined:
  - o_br_cnt increments on every res.
  - o_mispred_cnt increments on every o_flush.
  - Both saturate at 32'hFFFF_FFFF.
  - Both reset to 0.
- Undefined: both outputs tied to 0, no counter flops.

## Structure
- bp_pkg: bht_entry_t packed struct, counter encoding localparams, default BHT_IDX_W, and function sat_update(cnt, taken).
- Sub-module bp_bht:
  - Flop-array storage.
  - One combinational read port.
  - One synchronous write port.
  - Synchronous valid clear on i_rst.
- bp_ctrl holds the resolve/mispredict logic and the counters.

## Test plan
- Reset then i_if_pc=0x100 -> o_pred_taken=0, o_pred_target=0; counters 0.
- Two resolutions at 0x100 taken to 0x80, each with pred_taken=0:
  - Resolution 1 -> o_flush=1, o_redirect_pc=0x80.
  - Next cycle, lookup 0x100 -> pred_taken=1, target 0x80.
  - Resolution 2 -> cnt reaches ST.
- Loop exit:
  - Entry at ST; resolve not-taken with pred_taken=1 -> o_flush=1, o_redirect_pc=0x104, cnt becomes WT, prediction still taken.
  - Second not-taken -> WNT, predict not-taken.
- Target change: hit entry at WT; resolve taken to 0x200 with pred_target 0x80 -> o_flush=1, o_redirect_pc=0x200, target updated to 0x200.
- Alias and bypass:
  - 0x100 and 0x200 share an index (BHT_IDX_W=6). Resolve 0x200 taken to 0x40 while IF looks up 0x100 in the same cycle.
  - That cycle: lookup returns the old 0x100 entry.
  - Next cycle: 0x100 misses (tag mismatch).
- Reset and counters: assert i_rst during a resolution -> update discarded, all lookups miss next cycle. With BP_PERF_CNT_EN, 10 branches and 3 flushes -> o_br_cnt=10, o_mispred_cnt=3.
